// File: rtl/tiler_pkg.sv
// Shared types for the halo frame tiler: FSM state encoding and the
// descriptor layout at the default field width.
package tiler_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] core_row_idx;
        logic [DEF_WIDTH-1:0] core_col_idx;
        logic [DEF_WIDTH-1:0] core_rows;
        logic [DEF_WIDTH-1:0] core_cols;
        logic [DEF_WIDTH-1:0] tile_row_idx;
        logic [DEF_WIDTH-1:0] tile_col_idx;
        logic [DEF_WIDTH-1:0] tile_rows_out;
        logic [DEF_WIDTH-1:0] tile_cols_out;
        logic                 tile_last;
    } tile_desc_t;

endpackage

// File: rtl/tile_extent_calc.sv
// One-axis extent math: clips the core tile to the frame and derives the
// halo-expanded region, also clipped to the frame.
module tile_extent_calc #(
    parameter int WIDTH  = 16,
    parameter int HALO_W = 4
) (
    input  logic [WIDTH-1:0]  origin,
    input  logic [WIDTH-1:0]  size,
    input  logic [WIDTH-1:0]  extent,
    input  logic [HALO_W-1:0] halo,
    output logic [WIDTH-1:0]  core_size,
    output logic [WIDTH-1:0]  halo_origin,
    output logic [WIDTH-1:0]  halo_size
);

    logic [WIDTH:0]   remain;
    logic [WIDTH:0]   halo_end;
    logic [WIDTH-1:0] halo_w;
    logic [WIDTH-1:0] end_clip;

    // halo_end can exceed 2^WIDTH-1 near the frame edge, hence the extra bit
    always_comb begin
        halo_w      = WIDTH'(halo);
        remain      = {1'b0, extent} - {1'b0, origin};
        core_size   = ({1'b0, size} < remain) ? size : remain[WIDTH-1:0];
        halo_origin = (origin >= halo_w) ? origin - halo_w : '0;
        halo_end    = {1'b0, origin} + {1'b0, core_size} + {1'b0, halo_w};
        end_clip    = (halo_end < {1'b0, extent}) ? halo_end[WIDTH-1:0] : extent;
        halo_size   = end_clip - halo_origin;
    end

endmodule

// File: rtl/halo_frame_tiler.sv
// Walks a frame tile by tile and emits one registered core+halo descriptor
// per tile over valid/ready (a descriptor moves when tile_valid && tile_ready).
module halo_frame_tiler
    import tiler_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HALO_W = 4,
    parameter int CNT_W  = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              col_major,
    input  logic [WIDTH-1:0]  frame_H,
    input  logic [WIDTH-1:0]  frame_W,
    input  logic [WIDTH-1:0]  tile_rows,
    input  logic [WIDTH-1:0]  tile_cols_max,
    input  logic [HALO_W-1:0] halo_r,
    input  logic [HALO_W-1:0] halo_c,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [WIDTH-1:0]  core_row_idx,
    output logic [WIDTH-1:0]  core_col_idx,
    output logic [WIDTH-1:0]  core_rows,
    output logic [WIDTH-1:0]  core_cols,
    output logic [WIDTH-1:0]  tile_row_idx,
    output logic [WIDTH-1:0]  tile_col_idx,
    output logic [WIDTH-1:0]  tile_rows_out,
    output logic [WIDTH-1:0]  tile_cols_out,
    output logic              tile_last,
    output logic [CNT_W-1:0]  tile_count,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    state_e state_q, state_d;
    logic cm_q, cm_d;
    logic [WIDTH-1:0] fh_q, fh_d, fw_q, fw_d, tr_q, tr_d, tc_q, tc_d;
    logic [HALO_W-1:0] hr_q, hr_d, hc_q, hc_d;
    logic [WIDTH-1:0] row_q, row_d, col_q, col_d;
    logic valid_q, valid_d, last_q, last_d, busy_q, busy_d;
    logic done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] crows_q, crows_d, ccols_q, ccols_d;
    logic [WIDTH-1:0] trow_q, trow_d, tcol_q, tcol_d;
    logic [WIDTH-1:0] trows_q, trows_d, tcols_q, tcols_d;
    logic [WIDTH:0]   row_step, col_step;

    always_comb begin
        state_d  = state_q;
        cm_d     = cm_q;
        fh_d     = fh_q;
        fw_d     = fw_q;
        tr_d     = tr_q;
        tc_d     = tc_q;
        hr_d     = hr_q;
        hc_d     = hc_q;
        row_d    = row_q;
        col_d    = col_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        count_d  = count_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        row_step = {1'b0, row_q} + {1'b0, tr_q};
        col_step = {1'b0, col_q} + {1'b0, tc_q};
        case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    cm_d    = col_major;
                    fh_d    = frame_H;
                    fw_d    = frame_W;
                    tr_d    = tile_rows;
                    tc_d    = tile_cols_max;
                    hr_d    = halo_r;
                    hc_d    = halo_c;
                    row_d   = '0;
                    col_d   = '0;
                    count_d = '0;
                    if (frame_H == '0 || frame_W == '0 || tile_rows == '0 || tile_cols_max == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (valid_q && tile_ready) begin
                    count_d = count_q + CNT_W'(1);
                    if (last_q) begin
                        state_d = ST_FIN;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (!cm_q) begin
                        if (col_step >= {1'b0, fw_q}) begin
                            col_d = '0;
                            row_d = row_step[WIDTH-1:0];
                        end else begin
                            col_d = col_step[WIDTH-1:0];
                        end
                    end else begin
                        if (row_step >= {1'b0, fh_q}) begin
                            row_d = '0;
                            col_d = col_step[WIDTH-1:0];
                        end else begin
                            row_d = row_step[WIDTH-1:0];
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        // Last tile is the one whose row and column both reach the frame edge
        last_d = valid_d
               && (({1'b0, row_d} + {1'b0, tr_d}) >= {1'b0, fh_d})
               && (({1'b0, col_d} + {1'b0, tc_d}) >= {1'b0, fw_d});
    end

    tile_extent_calc #(.WIDTH(WIDTH), .HALO_W(HALO_W)) u_row_calc (
        .origin      (row_d),
        .size        (tr_d),
        .extent      (fh_d),
        .halo        (hr_d),
        .core_size   (crows_d),
        .halo_origin (trow_d),
        .halo_size   (trows_d)
    );

    tile_extent_calc #(.WIDTH(WIDTH), .HALO_W(HALO_W)) u_col_calc (
        .origin      (col_d),
        .size        (tc_d),
        .extent      (fw_d),
        .halo        (hc_d),
        .core_size   (ccols_d),
        .halo_origin (tcol_d),
        .halo_size   (tcols_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cm_q    <= 1'b0;
            fh_q    <= '0;
            fw_q    <= '0;
            tr_q    <= '0;
            tc_q    <= '0;
            hr_q    <= '0;
            hc_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            crows_q <= '0;
            ccols_q <= '0;
            trow_q  <= '0;
            tcol_q  <= '0;
            trows_q <= '0;
            tcols_q <= '0;
        end else begin
            state_q <= state_d;
            cm_q    <= cm_d;
            fh_q    <= fh_d;
            fw_q    <= fw_d;
            tr_q    <= tr_d;
            tc_q    <= tc_d;
            hr_q    <= hr_d;
            hc_q    <= hc_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
            crows_q <= crows_d;
            ccols_q <= ccols_d;
            trow_q  <= trow_d;
            tcol_q  <= tcol_d;
            trows_q <= trows_d;
            tcols_q <= tcols_d;
        end
    end

    assign tile_valid    = valid_q;
    assign core_row_idx  = row_q;
    assign core_col_idx  = col_q;
    assign core_rows     = crows_q;
    assign core_cols     = ccols_q;
    assign tile_row_idx  = trow_q;
    assign tile_col_idx  = tcol_q;
    assign tile_rows_out = trows_q;
    assign tile_cols_out = tcols_q;
    assign tile_last     = last_q;
    assign tile_count    = count_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_halo_frame_tiler.sv
// Bench for halo_frame_tiler: expected descriptor lists come from plain
// nested tile loops with min/max arithmetic, compared per handshake.
module tb_halo_frame_tiler;

    localparam int W   = 16;
    localparam int HW  = 4;
    localparam int CW  = 2 * W;
    localparam int DW  = 8 * W + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          col_major = 1'b0;
    logic [W-1:0]  frame_H = '0, frame_W = '0, tile_rows = '0, tile_cols_max = '0;
    logic [HW-1:0] halo_r = '0, halo_c = '0;
    logic          tile_ready = 1'b0;
    logic          tile_valid, tile_last, busy, done, cfg_err;
    logic [W-1:0]  core_row_idx, core_col_idx, core_rows, core_cols;
    logic [W-1:0]  tile_row_idx, tile_col_idx, tile_rows_out, tile_cols_out;
    logic [CW-1:0] tile_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    halo_frame_tiler #(.WIDTH(W), .HALO_W(HW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .col_major(col_major),
        .frame_H(frame_H), .frame_W(frame_W), .tile_rows(tile_rows), .tile_cols_max(tile_cols_max),
        .halo_r(halo_r), .halo_c(halo_c), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .core_row_idx(core_row_idx), .core_col_idx(core_col_idx), .core_rows(core_rows),
        .core_cols(core_cols), .tile_row_idx(tile_row_idx), .tile_col_idx(tile_col_idx),
        .tile_rows_out(tile_rows_out), .tile_cols_out(tile_cols_out), .tile_last(tile_last),
        .tile_count(tile_count), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    function automatic logic [DW-1:0] dut_desc();
        return {core_row_idx, core_col_idx, core_rows, core_cols,
                tile_row_idx, tile_col_idx, tile_rows_out, tile_cols_out, tile_last};
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] model_desc(int r, int c, int h, int w, int tr, int tc,
                                                 int hr, int hc, bit last);
        int cr, cc, hro, hco, hrs, hcs;
        cr  = imin(tr, h - r);
        cc  = imin(tc, w - c);
        hro = imax(r - hr, 0);
        hco = imax(c - hc, 0);
        hrs = imin(r + cr + hr, h) - hro;
        hcs = imin(c + cc + hc, w) - hco;
        return {W'(r), W'(c), W'(cr), W'(cc), W'(hro), W'(hco), W'(hrs), W'(hcs), last};
    endfunction

    task automatic build_expected(int h, int w, int tr, int tc, int hr, int hc, bit cm);
        int nr, nc, total, k;
        nr = (h + tr - 1) / tr;
        nc = (w + tc - 1) / tc;
        total = nr * nc;
        k = 0;
        exp_q.delete();
        for (int a = 0; a < (cm ? nc : nr); a++) begin
            for (int b = 0; b < (cm ? nr : nc); b++) begin
                k++;
                if (cm) exp_q.push_back(model_desc(b * tr, a * tc, h, w, tr, tc, hr, hc, k == total));
                else    exp_q.push_back(model_desc(a * tr, b * tc, h, w, tr, tc, hr, hc, k == total));
            end
        end
    endtask

    task automatic drive_start(int h, int w, int tr, int tc, int hr, int hc, bit cm);
        @(negedge clk);
        frame_H = W'(h); frame_W = W'(w); tile_rows = W'(tr); tile_cols_max = W'(tc);
        halo_r = HW'(hr); halo_c = HW'(hc); col_major = cm;
        start = 1'b1; tile_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one frame; stall_at holds ready low 3 cycles on that tile, abort_after aborts
    task automatic run_walk(string name, int h, int w, int tr, int tc, int hr, int hc, bit cm,
                            int rdy_pct, int stall_at, int abort_after);
        int total, hs_n, cyc, stall_left;
        bit fin, hold_chk;
        logic [DW-1:0] cur, held, expd;
        build_expected(h, w, tr, tc, hr, hc, cm);
        total = exp_q.size();
        hs_n = 0; cyc = 0; stall_left = 3; fin = 0; hold_chk = 0; held = '0;
        drive_start(h, w, tr, tc, hr, hc, cm);
        n_cmp++;
        if (tile_valid !== 1'b1 || busy !== 1'b1 || tile_count !== '0) begin
            n_bad++;
            $display("FAIL %s first_cycle: valid=%b busy=%b count=%0d need 1 1 0", name, tile_valid, busy, tile_count);
        end
        while (!fin && cyc < 4000) begin
            cur = dut_desc();
            if (hold_chk) begin
                n_cmp++;
                if (cur !== held) begin
                    n_bad++;
                    $display("FAIL %s hold_stable: got %h need %h", name, cur, held);
                end
            end
            n_cmp++;
            if (tile_count !== CW'(hs_n)) begin
                n_bad++;
                $display("FAIL %s count_track: got %0d need %0d", name, tile_count, hs_n);
            end
            if (hs_n == stall_at && stall_left > 0) begin
                tile_ready = 1'b0;
                stall_left--;
            end else begin
                tile_ready = ($urandom_range(99) < rdy_pct);
            end
            if (tile_valid !== 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL %s valid_drop: valid=%b at tile %0d of %0d", name, tile_valid, hs_n, total);
                fin = 1;
            end else if (tile_ready) begin
                hold_chk = 0;
                expd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_cmp++;
                if (cur !== expd) begin
                    n_bad++;
                    $display("FAIL %s desc%0d: got %h need %h", name, hs_n, cur, expd);
                end
                hs_n++;
                if (hs_n == abort_after) begin
                    @(negedge clk);
                    tile_ready = 1'b0; abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    n_cmp++;
                    if (tile_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tile_count !== CW'(hs_n)) begin
                        n_bad++;
                        $display("FAIL %s abort: valid=%b busy=%b done=%b count=%0d need 0 0 0 %0d",
                                 name, tile_valid, busy, done, tile_count, hs_n);
                    end
                    @(negedge clk);
                    n_cmp++;
                    if (done !== 1'b0 || tile_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s abort_no_done: done=%b valid=%b need 0 0", name, done, tile_valid);
                    end
                    fin = 1;
                end else if (hs_n == total) begin
                    @(negedge clk);
                    tile_ready = 1'b0;
                    n_cmp++;
                    if (done !== 1'b1 || cfg_err !== 1'b0 || tile_valid !== 1'b0 || busy !== 1'b0 || tile_count !== CW'(total)) begin
                        n_bad++;
                        $display("FAIL %s finish: done=%b err=%b valid=%b busy=%b count=%0d need 1 0 0 0 %0d",
                                 name, done, cfg_err, tile_valid, busy, tile_count, total);
                    end
                    @(negedge clk);
                    n_cmp++;
                    if (done !== 1'b0 || tile_count !== CW'(total)) begin
                        n_bad++;
                        $display("FAIL %s done_pulse: done=%b count=%0d need 0 %0d", name, done, tile_count, total);
                    end
                    fin = 1;
                end
            end else begin
                held = cur;
                hold_chk = 1;
            end
            if (!fin) @(negedge clk);
            cyc++;
        end
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: tiles=%0d need %0d", name, hs_n, total);
        end
        tile_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (tile_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 ||
            tile_count !== '0 || dut_desc() !== '0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b err=%b count=%0d desc=%h need all 0",
                     tile_valid, busy, done, cfg_err, tile_count, dut_desc());
        end
    endtask

    task automatic test_basic();
        run_walk("basic", 10, 14, 4, 5, 0, 0, 1'b0, 100, -1, -1);
    endtask

    task automatic test_halo();
        run_walk("halo", 10, 14, 4, 5, 1, 1, 1'b0, 100, -1, -1);
    endtask

    task automatic test_col_major();
        run_walk("col_major", 10, 14, 4, 5, 1, 1, 1'b1, 100, -1, -1);
    endtask

    task automatic test_stall();
        run_walk("stall", 10, 14, 4, 5, 2, 3, 1'b0, 100, 1, -1);
    endtask

    task automatic test_cfg_err();
        int n_done;
        bit err_ok, valid_seen;
        n_done = 0; err_ok = 1; valid_seen = 0;
        drive_start(10, 14, 0, 5, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) n_done++;
            if (cfg_err !== done) err_ok = 0;
            if (tile_valid !== 1'b0) valid_seen = 1;
            @(negedge clk);
        end
        n_cmp++;
        if (n_done != 1 || !err_ok || valid_seen || tile_count !== '0) begin
            n_bad++;
            $display("FAIL cfg_err: done_pulses=%0d err_match=%0d valid_seen=%0d count=%0d need 1 1 0 0",
                     n_done, err_ok, valid_seen, tile_count);
        end
    endtask

    task automatic test_abort();
        run_walk("abort", 10, 14, 4, 5, 0, 0, 1'b0, 100, -1, 4);
        run_walk("after_abort", 10, 14, 4, 5, 0, 0, 1'b0, 100, -1, -1);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 8; i++) begin
            run_walk("random", $urandom_range(20, 1), $urandom_range(20, 1), $urandom_range(8, 1),
                     $urandom_range(8, 1), $urandom_range(15, 0), $urandom_range(15, 0),
                     1'($urandom_range(1, 0)), 60, -1, -1);
        end
    endtask

    task automatic test_large();
        run_walk("large", 65535, 65535, 40000, 65535, 15, 15, 1'b0, 100, -1, -1);
        run_walk("large_cm", 65535, 65534, 65535, 30000, 15, 9, 1'b1, 70, -1, -1);
    endtask

    task automatic test_reset_mid_walk();
        drive_start(10, 14, 4, 5, 1, 1, 1'b0);
        tile_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        tile_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || tile_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_walk: done=%b valid=%b need 0 0", done, tile_valid);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_halo();
        test_col_major();
        test_stall();
        test_cfg_err();
        test_abort();
        test_back_to_back_random();
        test_large();
        test_reset_mid_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
